// File: rtl/etr_input_ctrl.sv
// etr_input_ctrl: ETR synchroniser, polarity, digital filter, edge detect and prescaler sequencing
module etr_input_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       aresetn_i,
  input  logic       etr_i,
  input  logic       ece_i,
  input  logic       etp_i,
  input  logic [1:0] etps_i,
  input  logic [3:0] etf_i,
  output logic       etrf_o,
  output logic       etr_flt_o,
  output logic [2:0] psc_cnt_o
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [6:0] cfg, cfg_q;
  logic [3:0] fcnt;
  logic [2:0] pcnt, ratio_m1;
  logic s, flt, flt_q, etrf, cfg_chg, leave, edge_det;
  assign cfg       = {etp_i, etps_i, etf_i};
  assign cfg_chg   = cfg != cfg_q;
  assign s         = sync[SYNC_STAGES-1] ^ etp_i;
  assign leave     = !ece_i || cfg_chg;
  assign ratio_m1  = 3'b111 >> (2'd3 - etps_i);
  assign edge_det  = state == RUN && flt && !flt_q && !leave;
  assign etrf_o    = etrf;
  assign etr_flt_o = flt;
  assign psc_cnt_o = pcnt;
  // State register; arming always passes through ARM so flt is preloaded without an edge
  always_ff @(posedge clk or negedge aresetn_i)
    if (!aresetn_i) state <= IDLE;
    else state <= state_nx;
  // Next state: a config change while running re-arms so counters never see a stale ratio
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (ece_i ? ARM : IDLE) :
               state == ARM  ? (ece_i ? RUN : IDLE) :
               (!ece_i ? IDLE : cfg_chg ? ARM : RUN);
  end
  // Sync chain, config history, filter, edge detect and prescaler
  always_ff @(posedge clk or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sync  <= '0;
      cfg_q <= '0;
      flt   <= 1'b0;
      flt_q <= 1'b0;
      fcnt  <= '0;
      pcnt  <= '0;
      etrf  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], etr_i};
      cfg_q <= cfg;
      etrf  <= 1'b0;
      if (state == IDLE) begin
        flt   <= 1'b0;
        flt_q <= 1'b0;
        fcnt  <= '0;
        pcnt  <= '0;
      end else if (state == ARM) begin
        flt   <= s;
        flt_q <= s;
        fcnt  <= '0;
        pcnt  <= '0;
      end else begin
        flt_q <= flt;
        if (s == flt) fcnt <= '0;
        else if (fcnt == etf_i) begin
          flt  <= s;
          fcnt <= '0;
        end else fcnt <= fcnt + 4'd1;
        if (leave) begin
          pcnt <= '0;
          fcnt <= '0;
        end else if (edge_det) begin
          if (pcnt == ratio_m1) begin
            pcnt <= '0;
            etrf <= 1'b1;
          end else pcnt <= pcnt + 3'd1;
        end
      end
    end
  end
endmodule
